// File: rtl/icache_pkg.sv
// Shared definitions for the ICache line-refill engine: FSM encoding, default geometry,
// derived widths and AXI read-burst constants.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_COMMIT
    } refill_state_t;

    localparam int DEF_LINE_WORDS = 8;
    localparam int DEF_INDEX_BITS = 7;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    function automatic int tag_bits(input int line_words, input int index_bits);
        return 32 - index_bits - $clog2(line_words) - 2;
    endfunction

    function automatic int ramad_bits(input int line_words, input int index_bits);
        return index_bits + $clog2(line_words);
    endfunction

endpackage

// File: rtl/icache_refill_if.sv
// AXI-style read-address and read-data channels between the refill engine (master)
// and the memory fabric (slave).
interface icache_refill_if;
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rready;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/icache_refill.sv
// ICache line-refill engine: one line-aligned INCR burst per miss, words streamed into
// the data RAM in order, tag/valid written last so a partial line never hits.
module icache_refill
    import icache_pkg::*;
#(
    parameter  int LINE_WORDS = DEF_LINE_WORDS,
    parameter  int INDEX_BITS = DEF_INDEX_BITS,
    localparam int OFF        = $clog2(LINE_WORDS),
    localparam int TAG_BITS   = tag_bits(LINE_WORDS, INDEX_BITS),
    localparam int RAMAD      = ramad_bits(LINE_WORDS, INDEX_BITS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                miss_req,
    input  logic [31:0]         miss_addr,
    output logic                refill_busy,
    output logic                refill_done,
    output logic                refill_err,
    icache_refill_if.master     bus,
    output logic                ram_wen,
    output logic [RAMAD-1:0]    ram_adw,
    output logic [31:0]         ram_din,
    output logic                tag_wen,
    output logic [INDEX_BITS-1:0] tag_idx,
    output logic [TAG_BITS:0]   tag_din
);

    localparam int LINE_BITS = 32 - OFF - 2;
    localparam logic [OFF:0] CNT_LAST = (OFF+1)'(LINE_WORDS - 1);

    refill_state_t         state;
    logic [LINE_BITS-1:0]  line_q;
    logic [OFF:0]          cnt_q;
    logic                  err_q;
    logic                  arvalid_q;
    logic                  rready_q;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  beat;
    logic                  overrun;
    logic                  beat_err;
    logic                  err_nxt;

    assign idx = line_q[INDEX_BITS-1:0];
    assign tag = line_q[LINE_BITS-1:INDEX_BITS];

    // Counter MSB set means the line is already full; such beats are drained, not written.
    assign beat     = (state == ST_DATA) && bus.rvalid;
    assign overrun  = cnt_q[OFF];
    assign beat_err = (bus.rresp != 2'b00) || overrun || (bus.rlast && (cnt_q != CNT_LAST));
    assign err_nxt  = err_q || (beat && beat_err);

    // NOTE: pure continuous assigns for the combinational outputs -- every path is driven, so no latch can form.
    assign ram_wen = beat && !overrun;
    assign ram_adw = {idx, cnt_q[OFF-1:0]};
    assign ram_din = (state == ST_DATA) ? bus.rdata : 32'h0;

    assign bus.arvalid = arvalid_q;
    assign bus.araddr  = {line_q, {(OFF+2){1'b0}}};
    assign bus.arlen   = 8'(LINE_WORDS - 1);
    assign bus.arsize  = AXI_SIZE_4B;
    assign bus.arburst = AXI_BURST_INCR;
    assign bus.rready  = rready_q;

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            line_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            refill_busy <= 1'b0;
            refill_done <= 1'b0;
            refill_err  <= 1'b0;
            tag_wen     <= 1'b0;
            tag_idx     <= '0;
            tag_din     <= '0;
        end else begin
            refill_done <= 1'b0;
            refill_err  <= 1'b0;
            tag_wen     <= 1'b0;
            tag_idx     <= '0;
            tag_din     <= '0;
            case (state)
                ST_IDLE: begin
                    err_q <= 1'b0;
                    cnt_q <= '0;
                    if (miss_req) begin
                        line_q      <= miss_addr[31:OFF+2];
                        arvalid_q   <= 1'b1;
                        refill_busy <= 1'b1;
                        state       <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bus.rvalid) begin
                        err_q <= err_nxt;
                        if (!overrun)
                            cnt_q <= cnt_q + (OFF+1)'(1);
                        if (bus.rlast) begin
                            rready_q    <= 1'b0;
                            refill_done <= 1'b1;
                            refill_err  <= err_nxt;
                            tag_wen     <= 1'b1;
                            tag_idx     <= idx;
                            tag_din     <= {~err_nxt, tag};
                            state       <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    refill_busy <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: clean, gapped, error, short/long and reset-interrupted
// refills, with RAM writes and AR handshakes captured by a monitor.
module tb_icache_refill;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_req = 1'b0;
    logic [31:0] miss_addr = 32'h0;
    logic        refill_busy, refill_done, refill_err;
    logic        ram_wen;
    logic [9:0]  ram_adw;
    logic [31:0] ram_din;
    logic        tag_wen;
    logic [6:0]  tag_idx;
    logic [20:0] tag_din;

    icache_refill_if bus ();

    icache_refill dut (
        .clk         (clk),
        .rst         (rst),
        .miss_req    (miss_req),
        .miss_addr   (miss_addr),
        .refill_busy (refill_busy),
        .refill_done (refill_done),
        .refill_err  (refill_err),
        .bus         (bus),
        .ram_wen     (ram_wen),
        .ram_adw     (ram_adw),
        .ram_din     (ram_din),
        .tag_wen     (tag_wen),
        .tag_idx     (tag_idx),
        .tag_din     (tag_din)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int ar_hs = 0;
    logic [9:0]  wr_adw[$];
    logic [31:0] wr_din[$];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        #2;
        if (ram_wen === 1'b1) begin
            wr_adw.push_back(ram_adw);
            wr_din.push_back(ram_din);
        end
        if (bus.arvalid === 1'b1 && bus.arready === 1'b1)
            ar_hs++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input int tno, input int b);
        return 32'hD0D0_0000 | 32'(tno << 8) | 32'(b);
    endfunction

    function automatic logic [127:0] all_outs();
        return {19'h0, refill_busy, refill_done, refill_err, bus.arvalid, bus.araddr,
                bus.rready, ram_wen, ram_adw, ram_din, tag_wen, tag_idx, tag_din};
    endfunction

    task automatic idle_bus();
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'h0;
        bus.rresp   = 2'b00;
        bus.rlast   = 1'b0;
    endtask

    task automatic do_miss(input int tno, input logic [31:0] addr, input bit hold,
                           input int ar_wait, input int nbeats, input int last_beat,
                           input int err_beat, input bit gapped,
                           input logic [31:0] exp_araddr, input logic [6:0] exp_idx,
                           input logic [19:0] exp_tag, input bit exp_err,
                           input int exp_writes, input int exp_lat);
        int acc;
        @(negedge clk);
        wr_adw.delete();
        wr_din.delete();
        ar_hs = 0;
        idle_bus();
        #1 check($sformatf("t%0d idle_busy", tno), 128'(refill_busy), 128'(0));
        miss_req  = 1'b1;
        miss_addr = addr;
        acc = cyc_n;

        @(negedge clk);
        miss_req    = hold;
        bus.arready = (ar_wait == 0);
        #1;
        check($sformatf("t%0d arvalid", tno), 128'(bus.arvalid), 128'(1));
        check($sformatf("t%0d araddr", tno), 128'(bus.araddr), 128'(exp_araddr));
        check($sformatf("t%0d arlen", tno), 128'(bus.arlen), 128'(7));
        check($sformatf("t%0d arsize", tno), 128'(bus.arsize), 128'(3'b010));
        check($sformatf("t%0d busy", tno), 128'(refill_busy), 128'(1));
        for (int k = 1; k <= ar_wait; k++) begin
            @(negedge clk);
            bus.arready = (k == ar_wait);
        end

        for (int b = 0; b < nbeats; b++) begin
            if (gapped && b > 0) begin
                for (int g = 0; g < (b % 3) + 1; g++) begin
                    @(negedge clk);
                    idle_bus();
                    #1 check($sformatf("t%0d gap_wen b%0d", tno, b), 128'(ram_wen), 128'(0));
                end
            end
            @(negedge clk);
            bus.arready = 1'b0;
            bus.rvalid  = 1'b1;
            bus.rdata   = beat_data(tno, b);
            bus.rresp   = (b == err_beat) ? 2'b10 : 2'b00;
            bus.rlast   = (b == last_beat);
            #1 check($sformatf("t%0d wen b%0d", tno, b), 128'(ram_wen), 128'(b < 8));
        end

        @(negedge clk);
        idle_bus();
        #1;
        check($sformatf("t%0d done", tno), 128'(refill_done), 128'(1));
        check($sformatf("t%0d err", tno), 128'(refill_err), 128'(exp_err));
        check($sformatf("t%0d tag_wen", tno), 128'(tag_wen), 128'(1));
        check($sformatf("t%0d tag_idx", tno), 128'(tag_idx), 128'(exp_idx));
        check($sformatf("t%0d tag_din", tno), 128'(tag_din), 128'({~exp_err, exp_tag}));
        if (exp_lat >= 0)
            check($sformatf("t%0d latency", tno), 128'(cyc_n - acc), 128'(exp_lat));

        @(negedge clk);
        miss_req = 1'b0;
        #1;
        check($sformatf("t%0d done_pulse", tno), 128'(refill_done), 128'(0));
        check($sformatf("t%0d tag_wen_pulse", tno), 128'(tag_wen), 128'(0));
        check($sformatf("t%0d busy_end", tno), 128'(refill_busy), 128'(0));

        repeat (2) @(negedge clk);
        #3;
        check($sformatf("t%0d ar_handshakes", tno), 128'(ar_hs), 128'(1));
        check($sformatf("t%0d busy_idle", tno), 128'(refill_busy), 128'(0));
        check($sformatf("t%0d n_writes", tno), 128'(wr_adw.size()), 128'(exp_writes));
        for (int i = 0; i < exp_writes && i < wr_adw.size(); i++) begin
            check($sformatf("t%0d adw w%0d", tno, i), 128'(wr_adw[i]), 128'(10'(exp_idx * 8 + i)));
            check($sformatf("t%0d din w%0d", tno, i), 128'(wr_din[i]), 128'(beat_data(tno, i)));
        end
    endtask

    initial begin
        idle_bus();
        #1 check("reset_outputs", all_outs(), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Clean burst, arready in the second ADDR cycle, done 11 cycles after accept.
        do_miss(1, 32'h1FC0_0124, 1'b0, 1, 8, 7, -1, 1'b0,
                32'h1FC0_0120, 7'h09, 20'h1FC00, 1'b0, 8, 11);
        // Same miss with 1-3 cycle rvalid gaps.
        do_miss(2, 32'h1FC0_0124, 1'b0, 1, 8, 7, -1, 1'b1,
                32'h1FC0_0120, 7'h09, 20'h1FC00, 1'b0, 8, -1);
        // SLVERR on beat 3: all words written, line left invalid.
        do_miss(3, 32'h1FC0_0124, 1'b0, 1, 8, 7, 3, 1'b0,
                32'h1FC0_0120, 7'h09, 20'h1FC00, 1'b1, 8, 11);
        // Early rlast on beat 5.
        do_miss(4, 32'h1FC0_0124, 1'b0, 1, 6, 5, -1, 1'b0,
                32'h1FC0_0120, 7'h09, 20'h1FC00, 1'b1, 6, -1);
        // Ten beats: the last two are drained without writing.
        do_miss(5, 32'h1FC0_0124, 1'b0, 1, 10, 9, -1, 1'b0,
                32'h1FC0_0120, 7'h09, 20'h1FC00, 1'b1, 8, -1);

        // Reset asserted mid-burst while beat 4 is on the bus.
        @(negedge clk);
        miss_req  = 1'b1;
        miss_addr = 32'h1FC0_0124;
        @(negedge clk);
        miss_req    = 1'b0;
        bus.arready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            bus.arready = 1'b0;
            bus.rvalid  = 1'b1;
            bus.rdata   = beat_data(6, b);
            bus.rlast   = 1'b0;
        end
        #3 rst = 1'b1;
        #1 check("async_reset_outputs", all_outs(), 128'(0));
        @(negedge clk);
        idle_bus();
        #1 check("reset_held_outputs", all_outs(), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        do_miss(7, 32'h8000_3FE8, 1'b0, 1, 8, 7, -1, 1'b0,
                32'h8000_3FE0, 7'h7F, 20'h80003, 1'b0, 8, 11);

        // miss_req held through COMMIT, immediate arready: minimum refill length.
        do_miss(8, 32'h0000_0040, 1'b1, 0, 8, 7, -1, 1'b0,
                32'h0000_0040, 7'h02, 20'h00000, 1'b0, 8, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
